gpr_write_port: RTL and testbench
=================================

// Module: gpr_write_port
// PURPOSE
//  Writer side of the GPR file write port. Merges single-cycle results from the MEM/WB pipeline with
//  results from long-latency units (mul/div) into the single write_enable/write_addr/write_data port.
//  Long results that cannot issue are buffered in a small in-order queue.
//  Exposes a pending-write lookup so decode can stall on hazards; raises a stall request when the queue is full.
// PARAMETERS
//  DATA_WIDTH   32  width of write data (matches `REGS_DATA_BUS)
//  ADDR_WIDTH   5   width of register address (matches `REGS_ADDR_BUS)
//  QUEUE_DEPTH  2   long-result queue entries (>=1; pointers wrap modulo QUEUE_DEPTH)
// PORTS
//  clock        in   1           single clock; all state on posedge
//  reset        in   1           asynchronous, active-low reset
//  pipe_valid   in   1           MEM/WB result valid this cycle (always accepted, never back-pressured)
//  pipe_addr    in   ADDR_WIDTH  MEM/WB destination register
//  pipe_data    in   DATA_WIDTH  MEM/WB result
//  lng_valid    in   1           long-unit result valid
//  lng_ready    out  1           long-unit result accepted when lng_valid && lng_ready
//  lng_addr     in   ADDR_WIDTH  long-unit destination register
//  lng_data     in   DATA_WIDTH  long-unit result
//  query_addr   in   ADDR_WIDTH  decode-stage source register to check
//  query_hit    out  1           a live queued write targets query_addr (combinational)
//  stall_req    out  1           queue full; pipeline control must stall issue of long ops
//  write_enable out  1           to GPR file write enable (registered)
//  write_addr   out  ADDR_WIDTH  to GPR file write address (registered)
//  write_data   out  DATA_WIDTH  to GPR file write data (registered)
// BEHAVIOUR
//  - Reset (reset low, async): write_enable=0, write_addr=0, write_data=0, queue empty, all entries dead.
//    lng_ready=1, stall_req=0, query_hit=0 while in reset. Reset mid-operation discards queued writes.
//  - Latency: selected write appears on write_* exactly 1 cycle after selection. Idle cycle -> write_enable=0,
//    write_addr/write_data hold their last value.
//  - Selection priority per cycle:
//    (1) pipe_valid && pipe_addr!=0 -> issue pipe write.
//    (2) else head entry live -> issue head, pop.
//    (3) else queue empty && lng accept && lng_addr!=0 -> issue lng directly (bypass, not enqueued).
//    (4) else nothing.
//  - lng_ready = (count != QUEUE_DEPTH). An accepted lng result is enqueued unless bypassed (3), dropped
//    (addr 0), or killed on entry (pipe write to the same addr in the same cycle: pipe result is younger, wins).
//  - Address 0: never issued. Pipe writes to 0 are ignored. Lng results to 0 complete the handshake and are
//    discarded.
//  - WAW kill: an issued pipe write marks every live queue entry with the same addr dead.
//    A dead head is popped with no write in the cycle it is at head; it may coincide with a pipe issue.
//    Count decrements on any pop.
//  - Simultaneous push and pop are allowed when full; lng_ready still follows the pre-pop count
//    (registered-count rule, no same-cycle reuse).
//  - query_hit = OR over live entries of (entry_addr == query_addr) && query_addr != 0. Dead entries and the
//    bypass path never hit.
//  - stall_req = (count == QUEUE_DEPTH).
//  - Queue is strictly in order. Head/tail pointers wrap at QUEUE_DEPTH. Count range 0..QUEUE_DEPTH.
// TESTING
//  1. Assert reset low mid-stream with 2 entries queued -> write_enable=0, write_addr=0, write_data=0,
//     lng_ready=1, query_hit=0. Release reset -> no stale writes appear.
//  2. pipe_valid, addr 5, data 0x00001234 -> next cycle write_enable=1, write_addr=5, write_data=0x00001234.
//  3. Pipe busy 3 cycles (addr 1,2,3), lng addr 7, data 0xAA in cycle 1 -> query_hit(7)=1 for 3 cycles;
//     addr 7 written the cycle after the last pipe write; query_hit clears.
//  4. DEPTH=2, pipe busy, two lng accepts -> lng_ready=0, stall_req=1. Third lng held until first pop;
//     order of writes 1st,2nd,3rd.
//  5. Queued addr 9, data 0x11; pipe writes addr 9, data 0x55 -> only 0x55 written to r9; entry popped
//     silently; query_hit(9)=0.
//  6. pipe addr 0 -> write_enable stays 0. Lng addr 0 with queue empty -> handshake completes,
//     no write, count unchanged.

Source files
------------

// File: rtl/gpr_write_port.sv
// GPR file write-port arbiter: merges single-cycle MEM/WB results with long-latency
// results, buffering long results in a small in-order queue with WAW kill and hazard lookup.
module gpr_write_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pipe_valid,
  input  logic [ADDR_WIDTH-1:0] pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  input  logic                  lng_valid,
  output logic                  lng_ready,
  input  logic [ADDR_WIDTH-1:0] lng_addr,
  input  logic [DATA_WIDTH-1:0] lng_data,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic                  query_hit,
  output logic                  stall_req,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(QUEUE_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  logic [ADDR_WIDTH-1:0]  q_addr_r [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  q_data_r [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_live_r;
  logic [QUEUE_DEPTH-1:0] live_nxt_s;
  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;

  logic                   pipe_issue_s;
  logic                   not_empty_s;
  logic                   head_live_s;
  logic                   lng_accept_s;
  logic                   bypass_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   issue_s;
  logic [ADDR_WIDTH-1:0]  issue_addr_s;
  logic [DATA_WIDTH-1:0]  issue_data_s;

  // A dead head is retired silently, even while the pipe owns the port.
  assign pipe_issue_s = pipe_valid && (pipe_addr != '0);
  assign not_empty_s  = (count_r != '0);
  assign head_live_s  = not_empty_s && q_live_r[head_r];
  assign lng_accept_s = lng_valid && (count_r != FULL_C);
  assign bypass_s     = !pipe_issue_s && !not_empty_s && lng_accept_s && (lng_addr != '0);
  assign pop_s        = not_empty_s && !(pipe_issue_s && head_live_s);
  assign push_s       = lng_accept_s && (lng_addr != '0) && !bypass_s &&
                        !(pipe_issue_s && (pipe_addr == lng_addr));
  assign lng_ready    = (count_r != FULL_C);
  assign stall_req    = (count_r == FULL_C);

  // Priority select of the write issued this cycle: pipe, then live head, then bypass.
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = pipe_addr;
    issue_data_s = pipe_data;
    if (pipe_issue_s) begin
      issue_s = 1'b1;
    end else if (head_live_s) begin
      issue_s      = 1'b1;
      issue_addr_s = q_addr_r[head_r];
      issue_data_s = q_data_r[head_r];
    end else if (bypass_s) begin
      issue_s      = 1'b1;
      issue_addr_s = lng_addr;
      issue_data_s = lng_data;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next liveness per entry: set on push, cleared by pipe WAW kill or pop.
  always_comb begin
    live_nxt_s = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      live_nxt_s[i] = (push_s && (tail_r == PTR_W'(i))) ||
                      (q_live_r[i] &&
                       !(pipe_issue_s && (q_addr_r[i] == pipe_addr)) &&
                       !(pop_s && (head_r == PTR_W'(i))));
    end
  end

  // Occupancy update; push and pop may coincide.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Hazard lookup over live entries only.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (q_live_r[i] && (q_addr_r[i] == query_addr) && (query_addr != '0)) begin
        query_hit = 1'b1;
      end else begin
        query_hit = query_hit;
      end
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_addr_r[i] <= '0;
        q_data_r[i] <= '0;
      end
      q_live_r <= '0;
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (push_s && (tail_r == PTR_W'(i))) begin
          q_addr_r[i] <= lng_addr;
          q_data_r[i] <= lng_data;
        end
      end
      q_live_r <= live_nxt_s;
      count_r  <= count_nxt_s;
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      if (push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
    end
  end

  // Registered write port; address/data hold on idle cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= issue_s;
      if (issue_s) begin
        write_addr <= issue_addr_s;
        write_data <= issue_data_s;
      end
    end
  end

endmodule

// File: tb/tb_gpr_write_port.sv
// Randomized and directed scoreboard bench for gpr_write_port with a queue-level reference model.
module tb_gpr_write_port;
  localparam int QD = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lng_valid;
  logic        lng_ready;
  logic [4:0]  lng_addr;
  logic [31:0] lng_data;
  logic [4:0]  query_addr;
  logic        query_hit;
  logic        stall_req;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  gpr_write_port #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .QUEUE_DEPTH(QD)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_addr(lng_addr), .lng_data(lng_data),
    .query_addr(query_addr), .query_hit(query_hit), .stall_req(stall_req),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clock = ~clock;

  typedef struct {logic [4:0] addr; logic [31:0] data; bit live;} ent_t;
  typedef struct {logic we; logic [4:0] addr; logic [31:0] data;} wr_t;

  ent_t        mq[$];
  wr_t         exp_q[$];
  logic [4:0]  last_a;
  logic [31:0] last_d;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] qa, output bit acc);
    bit  hit, piss, byp, pop;
    wr_t w;
    @(negedge clock);
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    lng_valid = lv; lng_addr = la; lng_data = ld; query_addr = qa;
    #1;
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == qa && qa != 5'd0) hit = 1'b1;
    chk("lng_ready", {31'd0, lng_ready}, {31'd0, mq.size() != QD});
    chk("stall_req", {31'd0, stall_req}, {31'd0, mq.size() == QD});
    chk("query_hit", {31'd0, query_hit}, {31'd0, hit});
    piss = pv && pa != 5'd0;
    acc  = lv && mq.size() < QD;
    byp  = 1'b0;
    w    = '{1'b0, last_a, last_d};
    if (piss) w = '{1'b1, pa, pd};
    else if (mq.size() > 0 && mq[0].live) w = '{1'b1, mq[0].addr, mq[0].data};
    else if (mq.size() == 0 && acc && la != 5'd0) begin
      byp = 1'b1;
      w   = '{1'b1, la, ld};
    end
    pop = mq.size() > 0 && !(piss && mq[0].live);
    if (piss) foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
    if (pop) void'(mq.pop_front());
    if (acc && la != 5'd0 && !byp && !(piss && pa == la)) mq.push_back('{la, ld, 1'b1});
    last_a = w.addr;
    last_d = w.data;
    exp_q.push_back(w);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_we"},   {31'd0, write_enable}, 32'd0);
    chk({tag, "_addr"}, {27'd0, write_addr}, 32'd0);
    chk({tag, "_data"}, write_data, 32'd0);
    chk({tag, "_rdy"},  {31'd0, lng_ready}, 32'd1);
    chk({tag, "_hit"},  {31'd0, query_hit}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
  endtask

  // Monitor: compares the registered write port one edge after each selection.
  initial begin
    wr_t w;
    forever begin
      @(posedge clock);
      #1;
      if (reset && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("wr_en", {31'd0, write_enable}, {31'd0, w.we});
        chk("wr_addr", {27'd0, write_addr}, {27'd0, w.addr});
        chk("wr_data", write_data, w.data);
      end
    end
  end

  initial begin
    bit acc;
    pipe_valid = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    lng_valid = 1'b0; lng_addr = 5'd0; lng_data = 32'd0; query_addr = 5'd0;
    last_a = 5'd0; last_d = 32'd0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset_checks("por");
    @(negedge clock);
    reset = 1'b1;

    // Plain pipe write, then address-0 cases.
    step(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 5'd0, acc);
    step(1'b1, 5'd0, 32'hDEAD_0000, 1'b0, 5'd0, 32'd0, 5'd0, acc);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 5'd0, acc);
    chk("lng0_acc", {31'd0, acc}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, acc);

    // Long result waits behind a busy pipe and is visible to the hazard lookup.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hAA, 5'd7, acc);
    step(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7, acc);
    step(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 5'd7, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, acc);

    // Fill the queue, then hold a third result until a slot frees.
    step(1'b1, 5'd1, 32'h10, 1'b1, 5'd10, 32'hA0, 5'd10, acc);
    step(1'b1, 5'd2, 32'h20, 1'b1, 5'd11, 32'hA1, 5'd11, acc);
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++)
      step((k == 0), 5'd3, 32'h30, 1'b1, 5'd12, 32'hA2, 5'd12, acc);
    chk("lng12_acc", {31'd0, acc}, 32'd1);
    repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, acc);

    // WAW kill: younger pipe write wins, queued entry retires silently.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h11, 5'd9, acc);
    step(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 5'd9, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, acc);

    // Reset mid-stream with two entries queued.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'hC0, 5'd20, acc);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'hC1, 5'd20, acc);
    @(negedge clock);
    pipe_valid = 1'b0; lng_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete(); mq.delete();
    last_a = 5'd0; last_d = 32'd0;
    #1;
    reset_checks("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, acc);

    // Random traffic over a small address range to provoke kills and hazards.
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), acc);

    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, acc);
    @(negedge clock);
    @(negedge clock);
    chk("drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
